// File: rtl/elem_minmax_reduce_if.sv
// Fixed-point context bundle: carries the element width, the clock and the reset.
// Latency: none, wiring only.
// Backpressure: none, carries no handshake.
interface fixedp #(
  parameter int WIDTH = 16
);
  logic clk;
  logic reset;

  modport master (output clk, reset);
  modport slave  (input  clk, reset);
endinterface

// File: rtl/elem_minmax_reduce.sv
// Streaming element-wise min/max reducer with per-element arg-index over a frame of matrix beats.
// Latency: result registered, out_valid rises the cycle after the last beat is accepted.
// Backpressure: in_ready drops while a result waits in DONE; the result holds until out_ready.
module elem_minmax_reduce #(
  parameter int ROWS   = 1,
  parameter int COLS   = 1,
  parameter int MAXLEN = 16,
  parameter int IDXW   = $clog2(MAXLEN)
) (
  fixedp.slave                                    g,
  input  logic [1:0]                              mode,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    in_last,
  input  logic [ROWS:1][COLS:1][g.WIDTH-1:0]      a,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ROWS:1][COLS:1][g.WIDTH-1:0]      f,
  output logic [ROWS:1][COLS:1][IDXW-1:0]         idx,
  output logic [IDXW:0]                           count,
  output logic                                    ovf
);

  localparam int W = g.WIDTH;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t               state;
  state_t               state_nx;
  logic                 accept;
  logic [1:0]           mode_q;
  logic [IDXW-1:0]      nidx;
  logic [ROWS:1][COLS:1] take;

  // Strict comparison: ties never replace, so the earliest beat keeps the extreme.
  // mode[1] selects unsigned, mode[0] selects max.
  function automatic logic better(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [1:0] m);
    logic lt;
    logic gt;
    if (m[1]) begin
      lt = (x < y);
      gt = (x > y);
    end else begin
      lt = ($signed(x) < $signed(y));
      gt = ($signed(x) > $signed(y));
    end
    return m[0] ? gt : lt;
  endfunction

  // State register.
  always_ff @(posedge g.clk) begin
    if (g.reset) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state and handshake outputs; no beat is taken while reset is asserted.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE, ACC: begin
        in_ready = !g.reset;
        accept   = in_valid && in_ready;
        if (accept) state_nx = in_last ? DONE : ACC;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Per-element replace decision under the mode latched on the first beat,
  // and the recorded index of the current beat, clipped once the index range is exhausted.
  always_comb begin
    take = '0;
    for (int r = 1; r <= ROWS; r++)
      for (int c = 1; c <= COLS; c++)
        take[r][c] = better(a[r][c], f[r][c], mode_q);
    if (count >= (IDXW+1)'(MAXLEN-1)) nidx = IDXW'(MAXLEN-1);
    else                              nidx = count[IDXW-1:0];
  end

  // Accumulators, arg-indices, beat counter and overflow flag; the first beat of a frame reloads everything.
  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      f      <= '0;
      idx    <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      mode_q <= 2'b00;
    end else if (accept) begin
      if (state == IDLE) begin
        f      <= a;
        idx    <= '0;
        count  <= (IDXW+1)'(1);
        ovf    <= 1'b0;
        mode_q <= mode;
      end else begin
        for (int r = 1; r <= ROWS; r++)
          for (int c = 1; c <= COLS; c++)
            if (take[r][c]) begin
              f[r][c]   <= a[r][c];
              idx[r][c] <= nidx;
            end
        if (count == (IDXW+1)'(MAXLEN)) ovf   <= 1'b1;
        else                            count <= count + (IDXW+1)'(1);
      end
    end
  end

endmodule
